digi_ota_bank: RTL and testbench
================================

// Module: digi_ota_bank
// PURPOSE
//  Clocked, multi-channel successor of the inverter-based digital OTA cell.
//  Each of CH channels samples a differential pair (vip/vin). It drives an
//  output only after the pair has disagreed with stable polarity for SETTLE
//  cycles. When the pair agrees, the output driver is released (oe=0).
//  Sits between the analog-pin sampling logic and the uo_out/uio_oe mux.
// PARAMETERS
//  CH          4   number of independent channels
//  SYNC_STAGES 2   input synchroniser depth (>=2)
//  SETTLE      4   consecutive same-polarity disagreeing samples before drive (>=1)
// PORTS
//  clk     in   1   single clock, all logic rising-edge
//  rst     in   1   synchronous, active-high reset
//  en      in   1   global enable; low forces all channels to HOLD
//  vip     in   CH  positive inputs, asynchronous
//  vin     in   CH  negative inputs, asynchronous
//  out     out  CH  decided output level per channel
//  oe      out  CH  output-drive enable per channel (1 only in DRIVE)
//  chg     out  CH  one-cycle pulse when a newly driven value differs from last driven
// BEHAVIOUR
//  - Reset: out=0, oe=0, chg=0, sync regs=0, state=HOLD, cnt=0, cand=0, last=0.
//  - Synchronisers run regardless of en. Per channel: diff = vip_s^vin_s, pol = vip_s.
//  - FSM per channel (cnt width $clog2(SETTLE+1), saturates at SETTLE):
//    HOLD : oe=0. If diff: cand<=pol, cnt<=1 -> QUAL (direct to DRIVE if SETTLE==1).
//    QUAL : oe=0. !diff -> HOLD, cnt<=0. diff&pol!=cand -> cand<=pol, cnt<=1, stay.
//           diff&pol==cand -> cnt++; when cnt+1==SETTLE -> DRIVE, out<=cand.
//    DRIVE: oe=1. !diff -> HOLD. diff&pol!=out -> QUAL, cand<=pol, cnt<=1.
//  - oe is registered; it is 1 exactly when state==DRIVE.
//  - Latency: a stable disagreeing input asserts oe SYNC_STAGES+SETTLE cycles after
//    the first edge that samples it. Release (agreement) drops oe SYNC_STAGES+1 cycles
//    after the first sampling edge.
//  - On DRIVE entry: last<=cand; chg=1 for that one cycle iff cand!=last.
//  - en low: next edge state=HOLD, cnt=0, oe=0, chg=0. out follows CONFIGURATION.
//    Re-enable requires a full SETTLE qualification.
//  - rst has priority over en. rst mid-operation returns everything to reset values
//    on the next edge.
//  - Channels are fully independent; simultaneous events on all channels are legal.
// CONFIGURATION
//  DIGI_OTA_KEEPER_EN defined: out retains last driven value in HOLD/QUAL (bus keeper).
//  DIGI_OTA_KEEPER_EN undefined: out is forced to 0 whenever oe=0.
//    last/chg tracking is unchanged.
// STRUCTURE
//  digi_ota_pkg: typedef enum logic [1:0] ota_state_t {ST_HOLD=0, ST_QUAL=1,
//    ST_DRIVE=2}; localparam defaults for CH/SYNC_STAGES/SETTLE.
//  Sub-module digi_ota_chan: synchroniser + FSM + cnt/cand/last for one channel.
//    Instantiated CH times in a generate loop. The top level only fans out clk/rst/en.
// TESTING (CH=4, SYNC_STAGES=2, SETTLE=4; both macro settings)
//  1 rst=1 3 cycles, random vip/vin -> out=0, oe=0, chg=0 on all channels.
//  2 ch0 vip=1,vin=0 held -> oe[0]=1,out[0]=1 at edge 6; chg[0]=1 for exactly 1 cycle.
//  3 ch1 1/0 for 3 cycles then 1/1 -> oe[1] never 1, chg[1] never 1.
//  4 ch2 1/0 2 cycles, then 0/1 held -> oe[2]=1, out[2]=0 at 6 cycles after flip;
//    chg[2]=0 (same as last=0).
//  5 ch0 in DRIVE(1), set 1/1 -> oe[0]=0 3 cycles later; out[0]=1 (KEEPER) / 0 (no KEEPER).
//    Then 0/1 held -> chg[0]=1.
//  6 en=0 at cnt=2, re-enable -> drive needs 4 further cycles. rst=1 in DRIVE ->
//    next cycle out=0, oe=0.

Source files
------------

// File: rtl/digi_ota_pkg.sv
// ============================================================================
// Module      : digi_ota_pkg
// Description : Shared types and default sizing for the digital OTA bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package digi_ota_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_DRIVE = 2'd2
    } ota_state_t;

    localparam int c_CH_DEFAULT          = 4;
    localparam int c_SYNC_STAGES_DEFAULT = 2;
    localparam int c_SETTLE_DEFAULT      = 4;

    // Qualification counter width: must be able to hold the value SETTLE itself.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/digi_ota_chan.sv
// ============================================================================
// Module      : digi_ota_chan
// Description : One OTA channel: input synchroniser, polarity-qualification
//               FSM and output tracking. Bus keeper on out when
//               DIGI_OTA_KEEPER_EN is defined, forced-low when released otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digi_ota_chan
    import digi_ota_pkg::*;
#(
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
    parameter int SETTLE      = c_SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_vip,
    input  logic i_vin,
    output logic o_out,
    output logic o_oe,
    output logic o_chg
);

    localparam int              c_CW     = cnt_width(SETTLE);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
    localparam logic [c_CW-1:0] c_ZERO   = '0;
    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE);

    localparam logic [1:0] c_ST_HOLD  = 2'(ST_HOLD);
    localparam logic [1:0] c_ST_QUAL  = 2'(ST_QUAL);
    localparam logic [1:0] c_ST_DRIVE = 2'(ST_DRIVE);

    logic [SYNC_STAGES-1:0] r_sync_p;
    logic [SYNC_STAGES-1:0] r_sync_n;
    logic [1:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_cand;
    logic                   r_last;
    logic                   r_oe;
    logic                   r_chg;

    logic                   w_vip_s;
    logic                   w_vin_s;
    logic                   w_diff;
    logic                   w_pol;
    logic [1:0]             w_state_nxt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_cand_nxt;
    logic                   w_enter_drive;
    logic                   w_qual_done;

    assign w_vip_s     = r_sync_p[SYNC_STAGES-1];
    assign w_vin_s     = r_sync_n[SYNC_STAGES-1];
    assign w_diff      = w_vip_s ^ w_vin_s;
    assign w_pol       = w_vip_s;
    assign w_qual_done = (c_CW'(r_cnt + c_ONE) >= c_SETTLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cand_nxt    = r_cand;
        w_enter_drive = 1'b0;

        if (!i_en) begin
            w_state_nxt = c_ST_HOLD;
            w_cnt_nxt   = c_ZERO;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (w_diff) begin
                        w_cand_nxt = w_pol;
                        w_cnt_nxt  = c_ONE;
                        if (SETTLE == 1) begin
                            w_state_nxt   = c_ST_DRIVE;
                            w_enter_drive = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_QUAL;
                        end
                    end
                end
                c_ST_QUAL: begin
                    if (!w_diff) begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = c_ZERO;
                    end else if (w_pol != r_cand) begin
                        w_cand_nxt = w_pol;
                        w_cnt_nxt  = c_ONE;
                    end else if (w_qual_done) begin
                        w_state_nxt   = c_ST_DRIVE;
                        w_cnt_nxt     = c_SETTLE;
                        w_enter_drive = 1'b1;
                    end else begin
                        w_cnt_nxt = c_CW'(r_cnt + c_ONE);
                    end
                end
                c_ST_DRIVE: begin
                    if (!w_diff) begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = c_ZERO;
                    end else if (w_pol != r_last) begin
                        // Polarity reversal while driving must requalify from scratch.
                        w_cand_nxt = w_pol;
                        w_cnt_nxt  = c_ONE;
                        if (SETTLE == 1) begin
                            w_state_nxt   = c_ST_DRIVE;
                            w_enter_drive = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_QUAL;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = c_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p <= '0;
            r_sync_n <= '0;
            r_state  <= c_ST_HOLD;
            r_cnt    <= c_ZERO;
            r_cand   <= 1'b0;
            r_last   <= 1'b0;
            r_oe     <= 1'b0;
            r_chg    <= 1'b0;
        end else begin
            r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], i_vip};
            r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], i_vin};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cand   <= w_cand_nxt;
            r_oe     <= (w_state_nxt == c_ST_DRIVE);
            r_chg    <= w_enter_drive && (w_cand_nxt != r_last);
            if (w_enter_drive) begin
                r_last <= w_cand_nxt;
            end
        end
    end

    // The last driven value doubles as the output level register.
`ifdef DIGI_OTA_KEEPER_EN
    assign o_out = r_last;
`else
    assign o_out = r_last & r_oe;
`endif
    assign o_oe  = r_oe;
    assign o_chg = r_chg;

endmodule

`default_nettype wire

// File: rtl/digi_ota_bank.sv
// ============================================================================
// Module      : digi_ota_bank
// Description : Multi-channel clocked digital OTA. Instantiates CH independent
//               channels; optional bus keeper via DIGI_OTA_KEEPER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digi_ota_bank
    import digi_ota_pkg::*;
#(
    parameter int CH          = c_CH_DEFAULT,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
    parameter int SETTLE      = c_SETTLE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] vip,
    input  logic [CH-1:0] vin,
    output logic [CH-1:0] out,
    output logic [CH-1:0] oe,
    output logic [CH-1:0] chg
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        digi_ota_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .SETTLE      (SETTLE)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .i_en  (en),
            .i_vip (vip[g]),
            .i_vin (vin[g]),
            .o_out (out[g]),
            .o_oe  (oe[g]),
            .o_chg (chg[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_digi_ota_bank.sv
// ============================================================================
// Module      : tb_digi_ota_bank
// Description : Directed self-checking bench for digi_ota_bank (CH=4,
//               SYNC_STAGES=2, SETTLE=4); honours DIGI_OTA_KEEPER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digi_ota_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] vip;
    logic [3:0] vin;
    logic [3:0] out;
    logic [3:0] oe;
    logic [3:0] chg;

    int n_pass  = 0;
    int n_total = 0;

`ifdef DIGI_OTA_KEEPER_EN
    localparam logic c_KEEP = 1'b1;
`else
    localparam logic c_KEEP = 1'b0;
`endif

    digi_ota_bank #(
        .CH          (4),
        .SYNC_STAGES (2),
        .SETTLE      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vip (vip),
        .vin (vin),
        .out (out),
        .oe  (oe),
        .chg (chg)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    logic seen_oe1;
    logic seen_chg1;

    initial begin
        // Reset with random pins
        rst = 1'b1;
        en  = 1'b1;
        vip = 4'($urandom);
        vin = 4'($urandom);
        tick(3);
        chk("rst_out", out, 4'b0000);
        chk("rst_oe",  oe,  4'b0000);
        chk("rst_chg", chg, 4'b0000);

        rst = 1'b0;
        vip = 4'b0000;
        vin = 4'b0000;
        tick(3);
        chk("idle_oe", oe, 4'b0000);

        // ch0 1/0 held: drive at edge 6
        vip[0] = 1'b1;
        tick(5);
        chk("ch0_edge5_oe", oe, 4'b0000);
        tick(1);
        chk("ch0_edge6_oe",  oe,  4'b0001);
        chk("ch0_edge6_out", out, 4'b0001);
        chk("ch0_edge6_chg", chg, 4'b0001);
        tick(1);
        chk("ch0_chg_pulse", chg, 4'b0000);
        chk("ch0_hold_oe",   oe,  4'b0001);

        // ch1 short disagreement never drives
        seen_oe1  = 1'b0;
        seen_chg1 = 1'b0;
        vip[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen_oe1  |= oe[1];
            seen_chg1 |= chg[1];
        end
        vin[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen_oe1  |= oe[1];
            seen_chg1 |= chg[1];
        end
        chk("ch1_never_oe",  {3'b000, seen_oe1},  4'b0000);
        chk("ch1_never_chg", {3'b000, seen_chg1}, 4'b0000);

        // ch2 polarity flip restarts qualification
        vip[2] = 1'b1;
        tick(2);
        vip[2] = 1'b0;
        vin[2] = 1'b1;
        tick(5);
        chk("ch2_flip5_oe", oe, 4'b0001);
        tick(1);
        chk("ch2_flip6_oe",  oe,  4'b0101);
        chk("ch2_flip6_out", out, 4'b0001);
        chk("ch2_flip6_chg", chg, 4'b0000);

        // ch0 release by agreement, then opposite polarity
        vin[0] = 1'b1;
        tick(2);
        chk("ch0_rel2_oe", oe, 4'b0101);
        tick(1);
        chk("ch0_rel3_oe",  oe,  4'b0100);
        chk("ch0_rel3_out", out, {3'b000, c_KEEP});
        vip[0] = 1'b0;
        tick(5);
        chk("ch0_neg5_oe",  oe,  4'b0100);
        chk("ch0_neg5_out", out, {3'b000, c_KEEP});
        tick(1);
        chk("ch0_neg6_oe",  oe,  4'b0101);
        chk("ch0_neg6_out", out, 4'b0000);
        chk("ch0_neg6_chg", chg, 4'b0001);
        tick(1);
        chk("ch0_neg7_chg", chg, 4'b0000);

        // ch3 disable at cnt=2, then re-enable
        vip[3] = 1'b1;
        tick(4);
        chk("ch3_cnt2_oe", oe, 4'b0101);
        en = 1'b0;
        tick(1);
        chk("dis_oe",  oe,  4'b0000);
        chk("dis_out", out, 4'b0000);
        chk("dis_chg", chg, 4'b0000);
        tick(2);
        chk("dis_hold_oe", oe, 4'b0000);
        en = 1'b1;
        tick(3);
        chk("ren3_oe", oe, 4'b0000);
        tick(1);
        chk("ren4_oe",  oe,  4'b1101);
        chk("ren4_out", out, 4'b1000);
        chk("ren4_chg", chg, 4'b1000);
        tick(1);
        chk("ren5_chg", chg, 4'b0000);

        // Reset while driving
        rst = 1'b1;
        tick(1);
        chk("mid_rst_out", out, 4'b0000);
        chk("mid_rst_oe",  oe,  4'b0000);
        chk("mid_rst_chg", chg, 4'b0000);
        rst = 1'b0;
        tick(5);
        chk("post_rst5_oe", oe, 4'b0000);
        tick(1);
        chk("post_rst6_oe",  oe,  4'b1101);
        chk("post_rst6_chg", chg, 4'b1000);

        // ch3 reversal while driving
        vip[3] = 1'b0;
        vin[3] = 1'b1;
        tick(2);
        chk("ch3_rev2_oe", oe, 4'b1101);
        tick(1);
        chk("ch3_rev3_oe",  oe,  4'b0101);
        chk("ch3_rev3_out", out, {c_KEEP, 3'b000});
        tick(2);
        chk("ch3_rev5_oe", oe, 4'b0101);
        tick(1);
        chk("ch3_rev6_oe",  oe,  4'b1101);
        chk("ch3_rev6_out", out, 4'b0000);
        chk("ch3_rev6_chg", chg, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
